// File: rtl/sel_rr_arbiter_pkg.sv
// Shared constants, state type and helpers for the round-robin select arbiter.
package sel_arb_pkg;
  localparam int SEL_W = 2;
  localparam int NREQ  = 1 << SEL_W;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction
endpackage

// File: rtl/sel_rr_arbiter_if.sv
// Request/select bundle between the four sources, the arbiter and the downstream mux.
// Handshake: req[i] is a level; the owner keeps it high to hold gnt, and sel/gnt are
// meaningful only while sel_valid=1. No back-pressure path exists.
interface sel_rr_arbiter_if;
  import sel_arb_pkg::*;

  logic              en;
  logic [NREQ-1:0]   req;
  logic [SEL_W-1:0]  sel;
  logic              sel_valid;
  logic [NREQ-1:0]   gnt;
  logic              timeout;
  state_t            state;

  modport master (output en, req, input sel, sel_valid, gnt, timeout, state);
  modport slave  (input en, req, output sel, sel_valid, gnt, timeout, state);
endinterface

// File: rtl/sel_rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set req bit at ptr, ptr+1, ... (mod 4).
module rr_pick4
  import sel_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate back to ptr so the nearest one is written last.
    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        for (int j = NREQ - 1; j >= 0; j--) begin
            cand = ptr + SEL_W'(j);
            if (req[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter with bounded hold, driving the select of a 4:1 mux; all outputs registered.
module sel_rr_arbiter
  import sel_arb_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sel_rr_arbiter_if.slave    bus
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_t            state, state_n;
    logic [SEL_W-1:0]  sel_q, sel_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic              valid_q, valid_n;
    logic [NREQ-1:0]   gnt_q, gnt_n;
    logic              to_q, to_n;
    logic [CNT_W-1:0]  hold_cnt, cnt_n;
    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            ptr      <= '0;
            valid_q  <= 1'b0;
            gnt_q    <= '0;
            to_q     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            ptr      <= ptr_n;
            valid_q  <= valid_n;
            gnt_q    <= gnt_n;
            to_q     <= to_n;
            hold_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        ptr_n   = ptr;
        valid_n = valid_q;
        gnt_n   = gnt_q;
        to_n    = 1'b0;
        cnt_n   = hold_cnt;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                gnt_n   = '0;
                if (bus.en && pick_any) begin
                    state_n = GRANT;
                    sel_n   = pick_idx;
                    valid_n = 1'b1;
                    gnt_n   = onehot(pick_idx);
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                // sel is left alone on release so the mux input stays stable through the gap.
                if (!bus.en || !bus.req[sel_q] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    gnt_n   = '0;
                    ptr_n   = sel_q + 1'b1;
                    cnt_n   = '0;
                    to_n    = bus.en && bus.req[sel_q];
                end else begin
                    cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = valid_q;
    assign bus.gnt       = gnt_q;
    assign bus.timeout   = to_q;
    assign bus.state     = state;
endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Bench for sel_rr_arbiter: two instances (MAX_HOLD=4 and 1) against a cycle-level reference model.
module tb_sel_rr_arbiter;
  import sel_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] req = 4'b0;
  always #5 clk = ~clk;

  sel_rr_arbiter_if if4 ();
  sel_rr_arbiter_if if1 ();
  assign if4.en  = en;
  assign if4.req = req;
  assign if1.en  = en;
  assign if1.req = req;

  sel_rr_arbiter #(.SEL_W(2), .MAX_HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  sel_rr_arbiter #(.SEL_W(2), .MAX_HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // ---------------- reference model ----------------
  // Per instance: whether someone owns the mux, who, where the search starts next,
  // how many cycles the owner has held so far, and whether the last release was forced.
  int   checks = 0;
  int   errors = 0;
  int   max_hold [2] = '{4, 1};
  bit   m_owned  [2];
  int   m_owner  [2];
  int   m_start  [2];
  int   m_held   [2];
  bit   m_forced [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owned[k] = 0; m_owner[k] = 0; m_start[k] = 0; m_held[k] = 0; m_forced[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic e, input logic [3:0] r);
    m_forced[k] = 0;
    if (!m_owned[k]) begin
      if (e) begin
        for (int j = 0; j < 4; j++) begin
          if (r[(m_start[k] + j) % 4]) begin
            m_owner[k] = (m_start[k] + j) % 4;
            m_owned[k] = 1;
            m_held[k]  = 1;
            break;
          end
        end
      end
    end else if (!e || !r[m_owner[k]]) begin
      m_owned[k] = 0;
      m_start[k] = (m_owner[k] + 1) % 4;
    end else if (m_held[k] == max_hold[k]) begin
      m_owned[k]  = 0;
      m_forced[k] = 1;
      m_start[k]  = (m_owner[k] + 1) % 4;
    end else begin
      m_held[k]++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input string name, input int k, input logic [1:0] s,
                            input logic sv, input logic [3:0] g, input logic to, input logic st);
    logic [3:0] exp_g;
    exp_g = m_owned[k] ? (4'b0001 << m_owner[k]) : 4'b0000;
    check_eq({name, ".sel"},       32'(s),  32'(m_owner[k]));
    check_eq({name, ".sel_valid"}, 32'(sv), 32'(m_owned[k]));
    check_eq({name, ".gnt"},       32'(g),  32'(exp_g));
    check_eq({name, ".timeout"},   32'(to), 32'(m_forced[k]));
    check_eq({name, ".state"},     32'(st), 32'(m_owned[k]));
  endtask

  task automatic check_all();
    check_inst("mh4", 0, if4.sel, if4.sel_valid, if4.gnt, if4.timeout, logic'(if4.state));
    check_inst("mh1", 1, if1.sel, if1.sel_valid, if1.gnt, if1.timeout, logic'(if1.state));
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge: drive, let one rising edge pass, then compare at the next negedge.
  task automatic run(input logic e, input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      en  = e;
      req = r;
      @(posedge clk);
      if (rst_n) begin
        model_edge(0, e, r);
        model_edge(1, e, r);
      end
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic reset_between_edges();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.sel",       32'(if4.sel),       32'd0);
    check_eq("rst.sel_valid", 32'(if4.sel_valid), 32'd0);
    check_eq("rst.gnt",       32'(if4.gnt),       32'd0);
    check_eq("rst.timeout",   32'(if4.timeout),   32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Reset in the middle of a grant to source 2, then restart from ptr=0.
    run(1'b1, 4'b0100, 3);
    reset_between_edges();
    run(1'b1, 4'b1111, 2);
    run(1'b0, 4'b0000, 2);

    // Source 0 requests briefly.
    reset_between_edges();
    run(1'b1, 4'b0001, 2);
    run(1'b1, 4'b0000, 3);

    // Everyone requesting: full rotation with forced releases.
    run(1'b1, 4'b1111, 26);
    run(1'b0, 4'b0000, 2);

    // Two sources alternating.
    run(1'b1, 4'b1010, 10);
    run(1'b0, 4'b0000, 2);

    // Owner 2 drops req on the same edge its hold limit is reached.
    run(1'b1, 4'b0100, 4);
    run(1'b1, 4'b0000, 2);

    // en dropped while source 3 owns.
    run(1'b1, 4'b1000, 2);
    run(1'b0, 4'b1000, 3);
    run(1'b1, 4'b1000, 3);

    // Random traffic with held request patterns.
    for (int n = 0; n < 60; n++) begin
      logic e;
      logic [3:0] r;
      e = ($urandom_range(0, 9) != 0);
      r = 4'($urandom_range(0, 15));
      run(e, r, $urandom_range(1, 8));
      if (n == 30) reset_between_edges();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
